// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel timer: register map, MODE codes,
// CTRL bit positions and the per-channel FSM state encoding.
package timer_pkg;

  localparam logic [1:0] RegCtrl   = 2'b00;
  localparam logic [1:0] RegPreset = 2'b01;
  localparam logic [1:0] RegCount  = 2'b10;
  localparam logic [1:0] RegStatus = 2'b11;

  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt
  } timer_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and the
// IDLE -> LOAD -> CNT down-counter FSM.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  reg_sel_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  timer_state_e  state_q, state_d;
  logic          en_q, en_d;
  logic [1:0]    mode_q, mode_d;
  logic          im_q, im_d;
  logic [CW-1:0] preset_q, preset_d;
  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;

  logic ctrl_we, preset_we, status_we;
  logic expire, auto_reload, set_pend;
  logic unused_wdata;

  assign ctrl_we     = we_i && (reg_sel_i == RegCtrl);
  assign preset_we   = we_i && (reg_sel_i == RegPreset);
  assign status_we   = we_i && (reg_sel_i == RegStatus);
  assign auto_reload = (mode_q == ModeAutoReload);
  assign expire      = (state_q == StCnt) && (count_q == '0);
  assign unused_wdata = ^wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StLoad: state_d = StCnt;
      StCnt:  if (expire && !auto_reload) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A CTRL write overrides the counting step taken on the same edge.
    if (ctrl_we) begin
      if (!wdata_i[CtrlEnBit]) begin
        state_d = StIdle;
      end else if (state_q == StIdle) begin
        state_d = StLoad;
      end
    end
  end

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    set_pend  = expire;

    if (state_q == StLoad) begin
      count_d = preset_q;
    end else if (state_q == StCnt) begin
      if (!expire) begin
        count_d = count_q - CW'(1);
      end else if (auto_reload) begin
        count_d = preset_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (ctrl_we) begin
      mode_d = wdata_i[CtrlModeMsb:CtrlModeLsb];
      im_d   = wdata_i[CtrlImBit];
      if (!wdata_i[CtrlEnBit]) begin
        en_d     = 1'b0;
        count_d  = count_q;
        set_pend = 1'b0;
      end else if (state_q == StIdle) begin
        en_d = 1'b1;
      end
    end

    if (preset_we) preset_d = wdata_i[CW-1:0];
    // Expiry wins over a same-edge W1C clear.
    if (status_we && wdata_i[0]) pending_d = 1'b0;
    if (set_pend) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      mode_q    <= ModeOneShot;
      im_q      <= 1'b0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    irq_o   = pending_q & im_q;
    rdata_o = '0;
    unique case (reg_sel_i)
      RegCtrl:   rdata_o[3:0] = {im_q, mode_q, en_q};
      RegPreset: rdata_o = 32'(preset_q);
      RegCount:  rdata_o = 32'(count_q);
      RegStatus: rdata_o[0] = pending_q;
      default:   rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_timer.sv
// NCH independent down-counting timers behind a small word-addressed
// register file; ADD_I[5:4] picks the channel, ADD_I[3:2] the register.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 32
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [5:2]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ
);

  logic [31:0]    ch_rdata [NCH];
  logic [NCH-1:0] ch_irq;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(
      .CW(CW)
    ) u_ch (
      .clk_i    (CLK_I),
      .rst_i    (RST_I),
      .reg_sel_i(ADD_I[3:2]),
      .we_i     (WE_I && (ADD_I[5:4] == 2'(i))),
      .wdata_i  (DAT_I),
      .rdata_o  (ch_rdata[i]),
      .irq_o    (ch_irq[i])
    );
  end

  // Channels at or above NCH never match, so they read as zero.
  always_comb begin
    DAT_O = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ADD_I[5:4] == 2'(i)) DAT_O = ch_rdata[i];
    end
  end

  assign IRQ = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus random register
// traffic against a cycle-level behavioural model; a second CW=8/NCH=1 instance.
module tb_multi_timer;

  logic        clk, rst;
  logic [5:2]  add_a, add_b;
  logic        we_a, we_b;
  logic [31:0] dat_a, dat_b, dat_o_a, dat_o_b;
  logic        irq_a, irq_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the default instance (2 channels, 32-bit).
  bit          m_en   [2];
  bit [1:0]    m_mode [2];
  bit          m_im   [2];
  logic [31:0] m_preset [2];
  logic [31:0] m_count  [2];
  bit          m_pend [2];
  bit          m_run  [2];
  bit          m_load [2];

  multi_timer u_dut_a (
    .CLK_I(clk), .RST_I(rst), .ADD_I(add_a), .WE_I(we_a),
    .DAT_I(dat_a), .DAT_O(dat_o_a), .IRQ(irq_a)
  );

  multi_timer #(.NCH(1), .CW(8)) u_dut_b (
    .CLK_I(clk), .RST_I(rst), .ADD_I(add_b), .WE_I(we_b),
    .DAT_I(dat_b), .DAT_O(dat_o_b), .IRQ(irq_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_preset[c] = 0;
      m_count[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_load[c] = 0;
    end
  endtask

  // One rising edge with the given bus write (if any) applied.
  task automatic model_step(input bit we, input int ch, input int r, input logic [31:0] data);
    for (int c = 0; c < 2; c++) begin
      logic [31:0] cnt;
      bit expire, was_idle;
      cnt = m_count[c];
      expire = 0;
      was_idle = !m_run[c] && !m_load[c];
      if (m_load[c]) begin
        cnt = m_preset[c]; m_load[c] = 0; m_run[c] = 1;
      end else if (m_run[c]) begin
        if (cnt != 0) cnt = cnt - 1;
        else begin
          expire = 1;
          if (m_mode[c] == 2'b01) cnt = m_preset[c];
          else begin m_run[c] = 0; m_en[c] = 0; end
        end
      end
      if (we && ch == c) begin
        if (r == 0) begin
          m_mode[c] = data[2:1];
          m_im[c] = data[3];
          if (!data[0]) begin
            m_run[c] = 0; m_load[c] = 0; m_en[c] = 0; cnt = m_count[c]; expire = 0;
          end else if (was_idle) begin
            m_en[c] = 1; m_load[c] = 1;
          end
        end else if (r == 1) begin
          m_preset[c] = data;
        end else if (r == 3 && data[0]) begin
          m_pend[c] = 0;
        end
      end
      if (expire) m_pend[c] = 1;
      m_count[c] = cnt;
    end
  endtask

  function automatic logic [31:0] model_read(input int c, input int r);
    if (c >= 2) return 32'h0;
    case (r)
      0: return {28'h0, m_im[c], m_mode[c], m_en[c]};
      1: return m_preset[c];
      2: return m_count[c];
      default: return {31'h0, m_pend[c]};
    endcase
  endfunction

  task automatic rd_a(input int ch, input int r, output logic [31:0] d);
    add_a = 4'((ch << 2) | r);
    #1;
    d = dat_o_a;
  endtask

  task automatic rd_b(input int ch, input int r, output logic [31:0] d);
    add_b = 4'((ch << 2) | r);
    #1;
    d = dat_o_b;
  endtask

  task automatic verify(input string tag);
    logic [31:0] d;
    bit irq_exp;
    irq_exp = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd_a(c, r, d);
        check_eq(tag, d, model_read(c, r));
      end
    end
    for (int c = 0; c < 2; c++) irq_exp = irq_exp | (m_pend[c] & m_im[c]);
    check_eq({tag, "_irq"}, 32'(irq_a), 32'(irq_exp));
  endtask

  task automatic step_a(input string tag, input bit we, input int ch, input int r,
                        input logic [31:0] data);
    we_a = we;
    add_a = 4'((ch << 2) | r);
    dat_a = data;
    @(posedge clk);
    model_step(we, ch, r, data);
    #1;
    we_a = 1'b0;
    verify(tag);
  endtask

  task automatic idle_a(input string tag);
    step_a(tag, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic step_b(input bit we, input int ch, input int r, input logic [31:0] data);
    we_b = we;
    add_b = 4'((ch << 2) | r);
    dat_b = data;
    @(posedge clk);
    #1;
    we_b = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int ch, r;
    bit we;
    logic [31:0] data;

    rst = 1'b1;
    we_a = 0; add_a = '0; dat_a = '0;
    we_b = 0; add_b = '0; dat_b = '0;
    model_reset();
    #5;
    verify("reset");
    @(negedge clk);
    rst = 1'b0;

    // One-shot on ch0 with IM.
    step_a("r031_preset", 1, 0, 1, 32'd5);
    step_a("r031_ctrl", 1, 0, 0, 32'h9);
    for (int i = 0; i < 6; i++) begin
      idle_a("r031_cnt");
      rd_a(0, 2, d);
      check_eq("r031_count", d, 32'(5 - i));
    end
    idle_a("r031_exp");
    rd_a(0, 3, d);
    check_eq("r031_pend", d, 32'h1);
    check_eq("r031_irq", 32'(irq_a), 32'h1);
    rd_a(0, 0, d);
    check_eq("r031_ctrl_rd", d, 32'h8);
    step_a("clr0", 1, 0, 3, 32'h1);

    // Auto-reload on ch1, W1C, and W1C on the exact expiry edge.
    step_a("r032_preset", 1, 1, 1, 32'd3);
    step_a("r032_ctrl", 1, 1, 0, 32'hB);
    repeat (4) idle_a("r032_run");
    rd_a(1, 3, d);
    check_eq("r032_pend_early", d, 32'h0);
    idle_a("r032_exp1");
    rd_a(1, 3, d);
    check_eq("r032_pend1", d, 32'h1);
    step_a("r032_w1c", 1, 1, 3, 32'h1);
    rd_a(1, 3, d);
    check_eq("r032_cleared", d, 32'h0);
    check_eq("r032_irq_low", 32'(irq_a), 32'h0);
    repeat (2) idle_a("r032_run2");
    idle_a("r032_exp2");
    rd_a(1, 3, d);
    check_eq("r032_pend2", d, 32'h1);
    repeat (3) idle_a("r033_run");
    step_a("r033_w1c_on_expiry", 1, 1, 3, 32'h1);
    rd_a(1, 3, d);
    check_eq("r033_set_wins", d, 32'h1);
    step_a("r033_stop", 1, 1, 0, 32'h8);

    // Disable mid-count holds COUNT; re-enable reloads PRESET.
    step_a("r034_preset", 1, 0, 1, 32'd100);
    step_a("r034_ctrl", 1, 0, 0, 32'h1);
    repeat (61) idle_a("r034_run");
    rd_a(0, 2, d);
    check_eq("r034_at40", d, 32'd40);
    step_a("r034_disable", 1, 0, 0, 32'h0);
    repeat (3) idle_a("r034_hold");
    rd_a(0, 2, d);
    check_eq("r034_held", d, 32'd40);
    rd_a(0, 3, d);
    check_eq("r034_no_pend", d, 32'h0);
    step_a("r034_reen", 1, 0, 0, 32'h1);
    idle_a("r034_load");
    rd_a(0, 2, d);
    check_eq("r034_reload", d, 32'd100);
    step_a("r034_stop", 1, 0, 0, 32'h0);

    // Asynchronous reset between edges at COUNT=7.
    step_a("r035_preset", 1, 0, 1, 32'd20);
    step_a("r035_ctrl", 1, 0, 0, 32'h9);
    repeat (14) idle_a("r035_run");
    rd_a(0, 2, d);
    check_eq("r035_at7", d, 32'd7);
    check_eq("r035_irq_before", 32'(irq_a), 32'h1);
    rst = 1'b1;
    model_reset();
    #1;
    verify("r035_async");
    rst = 1'b0;
    repeat (5) idle_a("r035_after");
    rd_a(0, 3, d);
    check_eq("r035_no_pend", d, 32'h0);

    // Random register traffic, including unimplemented channels.
    for (int i = 0; i < 400; i++) begin
      ch = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3));
      we = ($urandom_range(0, 9) < 3);
      data = $urandom;
      if (r == 1) data = 32'($urandom_range(0, 9));
      step_a("rand", we, ch, r, data);
    end

    // Narrow single-channel instance.
    step_b(1, 0, 1, 32'h1FF);
    rd_b(0, 1, d);
    check_eq("r036_preset_trunc", d, 32'hFF);
    rd_b(2, 1, d);
    check_eq("r036_ch2_preset", d, 32'h0);
    rd_b(2, 0, d);
    check_eq("r036_ch2_ctrl", d, 32'h0);
    step_b(1, 2, 1, 32'h55);
    step_b(1, 2, 0, 32'h1);
    step_b(0, 0, 0, 32'h0);
    rd_b(0, 1, d);
    check_eq("r036_ch0_preset_kept", d, 32'hFF);
    rd_b(0, 0, d);
    check_eq("r036_ch0_ctrl_kept", d, 32'h0);
    rd_b(0, 2, d);
    check_eq("r036_ch0_count_kept", d, 32'h0);
    step_b(1, 0, 1, 32'd2);
    step_b(1, 0, 0, 32'h9);
    repeat (3) step_b(0, 0, 0, 32'h0);
    rd_b(0, 2, d);
    check_eq("b_count_zero", d, 32'h0);
    rd_b(0, 3, d);
    check_eq("b_pend_early", d, 32'h0);
    step_b(0, 0, 0, 32'h0);
    rd_b(0, 3, d);
    check_eq("b_pend", d, 32'h1);
    check_eq("b_irq", 32'(irq_b), 32'h1);
    rd_b(0, 0, d);
    check_eq("b_ctrl", d, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NCH, default 2, number of independent timer channels (legal 1..4).
REQ-002 Parameter CW, default 32, counter and PRESET width in bits (legal 8..32).
REQ-003 CLK_I  input  1  system clock; all state changes on rising edge.
REQ-004 RST_I  input  1  reset; asynchronous, active-high.
REQ-005 ADD_I  input  [5:2]  word address: ADD_I[5:4] = channel index, ADD_I[3:2] = register (00 CTRL, 01 PRESET, 10 COUNT, 11 STATUS).
REQ-006 WE_I  input  1  write strobe, sampled on rising edge.
REQ-007 DAT_I  input  32  write data.
REQ-008 DAT_O  output  32  read data for addressed register, combinational from ADD_I.
REQ-009 IRQ  output  1  OR over channels of (pending AND interrupt-mask).

Function
REQ-010 CTRL layout: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), bit3 IM; other bits read 0, ignore writes.
REQ-011 PRESET is read/write; bits above CW read 0. COUNT is read-only (writes ignored), zero-extended to 32 bits.
REQ-012 STATUS bit0 = pending; writing 1 to bit0 clears it (W1C); writing 0 has no effect.
REQ-013 Accesses to channel index >= NCH: writes ignored, reads return 0.
REQ-014 Per-channel FSM states IDLE, LOAD, CNT.
REQ-015 IDLE: COUNT holds; a CTRL write with EN=1 moves to LOAD at that edge.
REQ-016 LOAD: COUNT <= PRESET, move to CNT (one cycle).
REQ-017 CNT, COUNT != 0: COUNT <= COUNT-1.
REQ-018 CNT, COUNT == 0, one-shot: pending <= 1, EN <= 0, move to IDLE; COUNT stays 0.
REQ-019 CNT, COUNT == 0, auto-reload: pending <= 1, COUNT <= current PRESET, stay CNT (period PRESET+1 cycles).
REQ-020 PRESET = 0: pending sets on the cycle after LOAD; auto-reload then sets pending every cycle.
REQ-021 CTRL write with EN=0 in any state: move to IDLE at that edge, COUNT holds value, pending unchanged.
REQ-022 CTRL write with EN=1 while already in LOAD/CNT: MODE/IM update only, no restart.
REQ-023 PRESET write during CNT: no effect on current count; used at next LOAD or reload.
REQ-024 Pending set and W1C clear on same edge: set wins, pending = 1.
REQ-025 IRQ is combinational from pending and IM; clearing IM deasserts IRQ while pending stays 1.
REQ-026 Channels fully independent; no shared state besides the read mux and IRQ OR.

Reset
REQ-027 On RST_I=1, immediately and regardless of clock: all CTRL, PRESET, COUNT, pending = 0, FSM = IDLE, IRQ = 0, DAT_O reflects zeroed registers.
REQ-028 Reset asserted mid-count aborts the count; no pending is generated on release.

Structure
REQ-029 Package timer_pkg holds register offset constants, MODE codes, CTRL bit positions and FSM state encoding.
REQ-030 One sub-module timer_channel (parameter CW) holds one channel's registers and FSM; multi_timer instantiates NCH copies via generate, decodes address, muxes DAT_O, ORs IRQ.

Verification
REQ-031 Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT 5,4,3,2,1,0 on successive cycles after LOAD, pending and IRQ rise on next edge, CTRL reads 0x8.
REQ-032 Ch1 PRESET=3, CTRL=0xB (auto-reload) -> pending sets every 4 cycles; W1C STATUS=1 clears it; IRQ drops until next expiry.
REQ-033 W1C to STATUS on exact expiry edge -> pending reads 1 afterwards.
REQ-034 Ch0 counting from 100, CTRL=0 at COUNT=40 -> COUNT holds 40, no pending; CTRL=0x1 -> reloads PRESET, not resume.
REQ-035 RST_I pulsed asynchronously (between edges) at COUNT=7 -> all reads 0 and IRQ=0 before next edge.
REQ-036 CW=8, NCH=1: PRESET write 0x1FF reads 0xFF; read at channel 2 returns 0; write there leaves ch0 unchanged.
